// File: rtl/stereo_gray_arbiter.sv
// stereo_gray_arbiter
//   Shares one RGB->gray converter between the left and right camera streams.
//   Each stream is buffered in its own FIFO. At most one pixel per cycle is
//   issued to the converter, round-robin between the two FIFOs. A side tag
//   travels alongside each issued pixel so that the returned gray value is
//   routed to the matching output.
//
//   Optional feature macro: GRAY_ARB_STATS_EN adds drop and busy counters.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   i_L_Red/Green/Blue, i_L_DVAL     left pixel in
//   i_R_Red/Green/Blue, i_R_DVAL     right pixel in
//   o_Red/Green/Blue, o_DVAL         pixel to converter (registered)
//   i_gray, i_gray_DVAL              converter result
//   o_L_gray/o_L_DVAL, o_R_gray/o_R_DVAL  routed gray results (registered)
//   o_ovf[1:0]                       sticky FIFO overflow {right, left}
//   o_sync_err                       sticky: result valid disagrees with tag
//   o_L_drop_cnt, o_R_drop_cnt       (stats) saturating drop counters
//   o_busy_cnt                       (stats) wrapping count of issue cycles
module stereo_gray_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int CONV_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_L_Red,
  input  logic [7:0]  i_L_Green,
  input  logic [7:0]  i_L_Blue,
  input  logic        i_L_DVAL,
  input  logic [7:0]  i_R_Red,
  input  logic [7:0]  i_R_Green,
  input  logic [7:0]  i_R_Blue,
  input  logic        i_R_DVAL,
  output logic [7:0]  o_Red,
  output logic [7:0]  o_Green,
  output logic [7:0]  o_Blue,
  output logic        o_DVAL,
  input  logic [7:0]  i_gray,
  input  logic        i_gray_DVAL,
  output logic [7:0]  o_L_gray,
  output logic [7:0]  o_R_gray,
  output logic        o_L_DVAL,
  output logic        o_R_DVAL,
  output logic [1:0]  o_ovf,
  output logic        o_sync_err
`ifdef GRAY_ARB_STATS_EN
  ,
  output logic [15:0] o_L_drop_cnt,
  output logic [15:0] o_R_drop_cnt,
  output logic [31:0] o_busy_cnt
`endif
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic        SIDE_L  = 1'b0;
  localparam logic        SIDE_R  = 1'b1;

  logic [23:0]         mem_l [FIFO_DEPTH];
  logic [23:0]         mem_r [FIFO_DEPTH];
  logic [AW:0]         wp_l, rp_l, wp_r, rp_r;
  logic                empty_l, empty_r, full_l, full_r;
  logic                gnt_v, gnt_side;
  logic                pop_l, pop_r, push_l, push_r, drop_l, drop_r;
  logic                last_grant, issue_side;
  logic [23:0]         head;
  logic [CONV_LAT-1:0] tag_v, tag_s;
  logic                tag_hit;

  // Extra pointer MSB distinguishes full from empty.
  assign empty_l = (wp_l == rp_l);
  assign empty_r = (wp_r == rp_r);
  assign full_l  = (wp_l[AW] != rp_l[AW]) && (wp_l[AW-1:0] == rp_l[AW-1:0]);
  assign full_r  = (wp_r[AW] != rp_r[AW]) && (wp_r[AW-1:0] == rp_r[AW-1:0]);

  always_comb begin
    gnt_v    = !empty_l || !empty_r;
    gnt_side = SIDE_L;
    if (!empty_l && !empty_r) gnt_side = ~last_grant;
    else if (empty_l)         gnt_side = SIDE_R;
  end

  assign pop_l  = gnt_v && (gnt_side == SIDE_L);
  assign pop_r  = gnt_v && (gnt_side == SIDE_R);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_l = i_L_DVAL && (!full_l || pop_l);
  assign push_r = i_R_DVAL && (!full_r || pop_r);
  assign drop_l = i_L_DVAL && full_l && !pop_l;
  assign drop_r = i_R_DVAL && full_r && !pop_r;
  assign head   = (gnt_side == SIDE_R) ? mem_r[rp_r[AW-1:0]] : mem_l[rp_l[AW-1:0]];

  // The tag pipe is fed from the registered issue, so its last stage lines up
  // with the converter result CONV_LAT cycles after o_DVAL.
  assign tag_hit = i_gray_DVAL && tag_v[CONV_LAT-1];

  always_ff @(posedge clk) begin
    if (push_l) mem_l[wp_l[AW-1:0]] <= {i_L_Red, i_L_Green, i_L_Blue};
    if (push_r) mem_r[wp_r[AW-1:0]] <= {i_R_Red, i_R_Green, i_R_Blue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_l       <= '0;
      rp_l       <= '0;
      wp_r       <= '0;
      rp_r       <= '0;
      last_grant <= SIDE_R;
      issue_side <= SIDE_L;
      o_Red      <= '0;
      o_Green    <= '0;
      o_Blue     <= '0;
      o_DVAL     <= 1'b0;
      tag_v      <= '0;
      tag_s      <= '0;
      o_L_gray   <= '0;
      o_R_gray   <= '0;
      o_L_DVAL   <= 1'b0;
      o_R_DVAL   <= 1'b0;
      o_ovf      <= '0;
      o_sync_err <= 1'b0;
    end else begin
      if (push_l) wp_l <= wp_l + PTR_ONE;
      if (push_r) wp_r <= wp_r + PTR_ONE;
      if (pop_l)  rp_l <= rp_l + PTR_ONE;
      if (pop_r)  rp_r <= rp_r + PTR_ONE;

      o_DVAL <= gnt_v;
      if (gnt_v) begin
        {o_Red, o_Green, o_Blue} <= head;
        last_grant <= gnt_side;
        issue_side <= gnt_side;
      end

      tag_v[0] <= o_DVAL;
      tag_s[0] <= issue_side;
      for (int i = 1; i < CONV_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_s[i] <= tag_s[i-1];
      end

      o_L_DVAL <= tag_hit && (tag_s[CONV_LAT-1] == SIDE_L);
      o_R_DVAL <= tag_hit && (tag_s[CONV_LAT-1] == SIDE_R);
      if (tag_hit && (tag_s[CONV_LAT-1] == SIDE_L)) o_L_gray <= i_gray;
      if (tag_hit && (tag_s[CONV_LAT-1] == SIDE_R)) o_R_gray <= i_gray;

      o_ovf      <= o_ovf | {drop_r, drop_l};
      o_sync_err <= o_sync_err | (i_gray_DVAL != tag_v[CONV_LAT-1]);
    end
  end

`ifdef GRAY_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_L_drop_cnt <= '0;
      o_R_drop_cnt <= '0;
      o_busy_cnt   <= '0;
    end else begin
      if (drop_l && (o_L_drop_cnt != 16'hFFFF)) o_L_drop_cnt <= o_L_drop_cnt + 16'd1;
      if (drop_r && (o_R_drop_cnt != 16'hFFFF)) o_R_drop_cnt <= o_R_drop_cnt + 16'd1;
      if (o_DVAL) o_busy_cnt <= o_busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stereo_gray_arbiter.sv
// Directed testbench for stereo_gray_arbiter. The converter is modelled as a
// 2-cycle delay with gray = Red.
module tb_stereo_gray_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_L_Red = '0, i_L_Green = '0, i_L_Blue = '0;
  logic [7:0] i_R_Red = '0, i_R_Green = '0, i_R_Blue = '0;
  logic       i_L_DVAL = 1'b0, i_R_DVAL = 1'b0;
  logic [7:0] o_Red, o_Green, o_Blue;
  logic       o_DVAL;
  logic [7:0] i_gray;
  logic       i_gray_DVAL;
  logic [7:0] o_L_gray, o_R_gray;
  logic       o_L_DVAL, o_R_DVAL;
  logic [1:0] o_ovf;
  logic       o_sync_err;
`ifdef GRAY_ARB_STATS_EN
  logic [15:0] o_L_drop_cnt, o_R_drop_cnt;
  logic [31:0] o_busy_cnt;
`endif

  stereo_gray_arbiter #(.FIFO_DEPTH(8), .CONV_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_L_Red(i_L_Red), .i_L_Green(i_L_Green), .i_L_Blue(i_L_Blue), .i_L_DVAL(i_L_DVAL),
    .i_R_Red(i_R_Red), .i_R_Green(i_R_Green), .i_R_Blue(i_R_Blue), .i_R_DVAL(i_R_DVAL),
    .o_Red(o_Red), .o_Green(o_Green), .o_Blue(o_Blue), .o_DVAL(o_DVAL),
    .i_gray(i_gray), .i_gray_DVAL(i_gray_DVAL),
    .o_L_gray(o_L_gray), .o_R_gray(o_R_gray), .o_L_DVAL(o_L_DVAL), .o_R_DVAL(o_R_DVAL),
    .o_ovf(o_ovf), .o_sync_err(o_sync_err)
`ifdef GRAY_ARB_STATS_EN
    , .o_L_drop_cnt(o_L_drop_cnt), .o_R_drop_cnt(o_R_drop_cnt), .o_busy_cnt(o_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Converter model: 2-cycle delay, gray = Red, flushed by reset.
  logic       cv1, cv2, inject = 1'b0;
  logic [7:0] cg1, cg2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv1 <= 1'b0; cv2 <= 1'b0; cg1 <= '0; cg2 <= '0;
    end else begin
      cv1 <= o_DVAL; cg1 <= o_Red; cv2 <= cv1; cg2 <= cg1;
    end
  end
  assign i_gray_DVAL = cv2 | inject;
  assign i_gray      = cg2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  ql[$], qr[$];
  int          qlc[$];
  logic [23:0] qi[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_L_DVAL) begin ql.push_back(o_L_gray); qlc.push_back(cyc); end
      if (o_R_DVAL) qr.push_back(o_R_gray);
      if (o_DVAL)   qi.push_back({o_Red, o_Green, o_Blue});
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic clear_q();
    ql.delete(); qr.delete(); qlc.delete(); qi.delete();
  endtask

  task automatic drive(input logic lv, input logic [7:0] lr, input logic rv, input logic [7:0] rr);
    i_L_DVAL = lv; i_L_Red = lr; i_L_Green = lr + 8'd1; i_L_Blue = lr + 8'd2;
    i_R_DVAL = rv; i_R_Red = rr; i_R_Green = rr + 8'd1; i_R_Blue = rr + 8'd2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    i_L_DVAL = 1'b0; i_R_DVAL = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_DVAL !== 1'b0) begin n_fail++; $display("FAIL reset_o_DVAL got %0b want 0", o_DVAL); end
    n_checks++; if ({o_Red, o_Green, o_Blue} !== 24'h0) begin n_fail++; $display("FAIL reset_o_RGB got %h want 0", {o_Red, o_Green, o_Blue}); end
    n_checks++; if ({o_L_DVAL, o_R_DVAL} !== 2'b00) begin n_fail++; $display("FAIL reset_out_dval got %b want 00", {o_L_DVAL, o_R_DVAL}); end
    n_checks++; if ({o_L_gray, o_R_gray} !== 16'h0) begin n_fail++; $display("FAIL reset_gray got %h want 0", {o_L_gray, o_R_gray}); end
    n_checks++; if ({o_ovf, o_sync_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {o_ovf, o_sync_err}); end
  endtask

  task automatic test_left_burst();
    int c0;
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(10 + i), 1'b0, 8'd0);
    idle(12);
    n_checks++; if (ql.size() != 4) begin n_fail++; $display("FAIL burst_l_count got %0d want 4", ql.size()); end
    for (int i = 0; i < 4 && i < ql.size(); i++) begin
      n_checks++; if (ql[i] !== 8'(10 + i)) begin n_fail++; $display("FAIL burst_l_val[%0d] got %0d want %0d", i, ql[i], 10 + i); end
      n_checks++; if (qlc[i] != c0 + 5 + i) begin n_fail++; $display("FAIL burst_l_cycle[%0d] got %0d want %0d", i, qlc[i] - c0, 5 + i); end
    end
    n_checks++; if (qr.size() != 0) begin n_fail++; $display("FAIL burst_r_count got %0d want 0", qr.size()); end
    n_checks++; if (o_ovf !== 2'b00) begin n_fail++; $display("FAIL burst_ovf got %b want 00", o_ovf); end
  endtask

  task automatic test_interleave();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(1 + i), 1'b1, 8'(101 + i));
    idle(14);
    n_checks++; if (qi.size() != 8) begin n_fail++; $display("FAIL ilv_issue_count got %0d want 8", qi.size()); end
    for (int i = 0; i < 8 && i < qi.size(); i++) begin
      v = (i % 2 == 0) ? 8'(1 + i / 2) : 8'(101 + i / 2);
      n_checks++;
      if (qi[i] !== {v, 8'(v + 8'd1), 8'(v + 8'd2)}) begin
        n_fail++; $display("FAIL ilv_issue[%0d] got %h want %h", i, qi[i], {v, 8'(v + 8'd1), 8'(v + 8'd2)});
      end
    end
    n_checks++; if (ql.size() != 4 || qr.size() != 4) begin n_fail++; $display("FAIL ilv_counts got %0d/%0d want 4/4", ql.size(), qr.size()); end
    for (int i = 0; i < 4 && i < ql.size() && i < qr.size(); i++) begin
      n_checks++; if (ql[i] !== 8'(1 + i) || qr[i] !== 8'(101 + i)) begin n_fail++; $display("FAIL ilv_out[%0d] got %0d/%0d want %0d/%0d", i, ql[i], qr[i], 1 + i, 101 + i); end
    end
    n_checks++; if (o_DVAL !== 1'b0 || o_Red !== 8'd104) begin n_fail++; $display("FAIL ilv_hold got dval %0b red %0d want 0 104", o_DVAL, o_Red); end
    n_checks++; if (o_ovf !== 2'b00) begin n_fail++; $display("FAIL ilv_ovf got %b want 00", o_ovf); end
  endtask

  // With alternating grants, left drops at input cycles 16,18 and right at 15,17,19.
  task automatic test_overflow();
    logic [7:0] el[$], er[$];
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(1 + i), 1'b1, 8'(101 + i));
    idle(50);
    for (int i = 0; i < 20; i++) begin
      if (i != 16 && i != 18) el.push_back(8'(1 + i));
      if (i != 15 && i != 17 && i != 19) er.push_back(8'(101 + i));
    end
    n_checks++; if (o_ovf !== 2'b11) begin n_fail++; $display("FAIL ovf_flags got %b want 11", o_ovf); end
    n_checks++; if (ql.size() != el.size()) begin n_fail++; $display("FAIL ovf_l_count got %0d want %0d", ql.size(), el.size()); end
    n_checks++; if (qr.size() != er.size()) begin n_fail++; $display("FAIL ovf_r_count got %0d want %0d", qr.size(), er.size()); end
    for (int i = 0; i < el.size() && i < ql.size(); i++) begin
      n_checks++; if (ql[i] !== el[i]) begin n_fail++; $display("FAIL ovf_l[%0d] got %0d want %0d", i, ql[i], el[i]); end
    end
    for (int i = 0; i < er.size() && i < qr.size(); i++) begin
      n_checks++; if (qr[i] !== er[i]) begin n_fail++; $display("FAIL ovf_r[%0d] got %0d want %0d", i, qr[i], er[i]); end
    end
`ifdef GRAY_ARB_STATS_EN
    n_checks++; if (o_L_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL stats_l_drop got %0d want 2", o_L_drop_cnt); end
    n_checks++; if (o_R_drop_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_r_drop got %0d want 3", o_R_drop_cnt); end
    n_checks++; if (o_busy_cnt !== 32'd35) begin n_fail++; $display("FAIL stats_busy got %0d want 35", o_busy_cnt); end
`endif
  endtask

  // Left FIFO is full at input cycle 15 while being granted; its push must land.
  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 15; i++) drive(1'b1, 8'(1 + i), 1'b1, 8'(101 + i));
    drive(1'b1, 8'd16, 1'b0, 8'd0);
    idle(45);
    n_checks++; if (o_ovf !== 2'b00) begin n_fail++; $display("FAIL fpp_ovf got %b want 00", o_ovf); end
    n_checks++; if (ql.size() != 16 || qr.size() != 15) begin n_fail++; $display("FAIL fpp_counts got %0d/%0d want 16/15", ql.size(), qr.size()); end
    for (int i = 0; i < 16 && i < ql.size(); i++) begin
      n_checks++; if (ql[i] !== 8'(1 + i)) begin n_fail++; $display("FAIL fpp_l[%0d] got %0d want %0d", i, ql[i], 1 + i); end
    end
  endtask

  task automatic test_sync_err();
    do_reset();
    idle(3);
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    n_checks++; if (o_sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_set got %0b want 1", o_sync_err); end
    n_checks++; if ({o_L_DVAL, o_R_DVAL} !== 2'b00) begin n_fail++; $display("FAIL sync_no_dval got %b want 00", {o_L_DVAL, o_R_DVAL}); end
    idle(5);
    n_checks++; if (o_sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_sticky got %0b want 1", o_sync_err); end
    n_checks++; if (ql.size() + qr.size() != 0) begin n_fail++; $display("FAIL sync_outputs got %0d want 0", ql.size() + qr.size()); end
  endtask

  task automatic test_reset_flush();
    int c0;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(40 + i), 1'b1, 8'(140 + i));
    i_L_DVAL = 1'b0; i_R_DVAL = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({o_DVAL, o_L_DVAL, o_R_DVAL} !== 3'b000) begin n_fail++; $display("FAIL flush_dvals got %b want 000", {o_DVAL, o_L_DVAL, o_R_DVAL}); end
    n_checks++; if ({o_Red, o_Green, o_Blue, o_L_gray, o_R_gray} !== 40'h0) begin n_fail++; $display("FAIL flush_data got %h want 0", {o_Red, o_Green, o_Blue, o_L_gray, o_R_gray}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_q();
    idle(10);
    n_checks++; if (ql.size() + qr.size() + qi.size() != 0) begin n_fail++; $display("FAIL flush_quiet got %0d want 0", ql.size() + qr.size() + qi.size()); end
    c0 = cyc;
    drive(1'b1, 8'd77, 1'b0, 8'd0);
    idle(8);
    n_checks++; if (ql.size() != 1) begin n_fail++; $display("FAIL flush_new_count got %0d want 1", ql.size()); end
    if (ql.size() > 0) begin
      n_checks++; if (ql[0] !== 8'd77 || qlc[0] != c0 + 5) begin n_fail++; $display("FAIL flush_new got val %0d lat %0d want 77 5", ql[0], qlc[0] - c0); end
    end
    n_checks++; if ({o_ovf, o_sync_err} !== 3'b000) begin n_fail++; $display("FAIL flush_flags got %b want 000", {o_ovf, o_sync_err}); end
  endtask

  initial begin
    test_reset();
    test_left_burst();
    test_interleave();
    test_overflow();
    test_full_pushpop();
    test_sync_err();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
